// File: rtl/game_pkg.sv
// Shared constants for the game controller: direction encodings, the
// direction-input FSM state encoding, board dimensions and the priority
// encoder used to turn simultaneous presses into a single request.
package game_pkg;

   localparam int NUM_KEYS = 4;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
   localparam logic [1:0] ST_HOLD_ENC    = 2'd1;
   localparam logic [1:0] ST_RELEASE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = ST_IDLE_ENC,
      ST_HOLD    = ST_HOLD_ENC,
      ST_RELEASE = ST_RELEASE_ENC
   } dir_state_e;

   // Playfield size, shared with the controller that consumes directions.
   localparam int BOARD_COLS = 16;
   localparam int BOARD_ROWS = 12;

   // Lowest-index event wins: up > down > left > right.
   function automatic logic [3:0] dir_select(input logic [3:0] ev);
      logic [3:0] sel;
      sel = DIR_NONE;
      if (ev[0])      sel = DIR_UP;
      else if (ev[1]) sel = DIR_DOWN;
      else if (ev[2]) sel = DIR_LEFT;
      else if (ev[3]) sel = DIR_RIGHT;
      return sel;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchroniser on the raw active-low
// button followed by a stability counter. level_o is active-high and only
// changes after DEBOUNCE_CYCLES consecutive samples disagree with it.
module key_debounce
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n_i,
   output logic level_o
);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             pressed;

   // Synchroniser flops start at the released level so a held key is not
   // seen as pressed straight out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = ~sync2_q;

   // Count consecutive disagreeing samples; toggle the level on the last one.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (pressed != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounced level and stability counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/direction_input.sv
// Direction input stage: debounces four active-low buttons and presents a
// one-hot direction request that is held until acknowledged or timed out,
// so a controller running on a divided clock cannot miss it. One physical
// press produces at most one request; all keys must be released before the
// next request can be issued.
// Optional feature macro: DIR_AUTOREPEAT_EN (re-issue the request while the
// originating key stays held; disabled by default).
module direction_input
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 16,
   parameter int CNT_W           = 18
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] key_n,
   input  logic       dir_ack,
   output logic [3:0] direction,
   output logic       dir_valid,
   output logic [3:0] key_level
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES);

`ifdef DIR_AUTOREPEAT_EN
   localparam int REPEAT_FIRST = 24_000_000;
   localparam int REPEAT_NEXT  = 8_000_000;
   localparam int RPT_W        = 25;
`endif

   logic [3:0]        level_w;
   logic [3:0]        level_prev_q;
   logic [3:0]        press_ev;
   dir_state_e        state_q;
   dir_state_e        state_d;
   logic [3:0]        dir_q;
   logic [3:0]        dir_d;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;

`ifdef DIR_AUTOREPEAT_EN
   logic [3:0]        origin_q;
   logic [3:0]        origin_d;
   logic [RPT_W-1:0]  rpt_cnt_q;
   logic [RPT_W-1:0]  rpt_cnt_d;
   logic              rpt_first_q;
   logic              rpt_first_d;
   logic              rpt_held;
   logic [RPT_W-1:0]  rpt_limit;
`endif

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_key_debounce (
         .clock   (clock),
         .reset_n (reset_n),
         .key_n_i (key_n[g]),
         .level_o (level_w[g])
      );
   end

   assign key_level = level_w;
   assign press_ev  = level_w & ~level_prev_q;

   // Previous debounced level, for rising-edge (press) detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) level_prev_q <= '0;
      else          level_prev_q <= level_w;
   end

`ifdef DIR_AUTOREPEAT_EN
   assign rpt_held  = (level_w & origin_q) != 4'b0000;
   assign rpt_limit = rpt_first_q ? RPT_W'(REPEAT_FIRST - 1) : RPT_W'(REPEAT_NEXT - 1);
`endif

   // Next-state logic: IDLE accepts a press, HOLD presents it, RELEASE waits
   // for every key to go up (presses seen outside IDLE are dropped).
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
`ifdef DIR_AUTOREPEAT_EN
      origin_d    = origin_q;
      rpt_first_d = rpt_first_q;
      rpt_cnt_d   = rpt_held ? rpt_cnt_q + 1'b1 : '0;
`endif
      case (state_q)
         ST_IDLE: begin
            hold_d = '0;
            if (press_ev != 4'b0000) begin
               dir_d   = dir_select(press_ev);
               state_d = ST_HOLD;
`ifdef DIR_AUTOREPEAT_EN
               origin_d    = dir_select(press_ev);
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b1;
`endif
            end
         end
         ST_HOLD: begin
            if (dir_ack || (hold_q == HOLD_W'(HOLD_CYCLES - 1))) begin
               dir_d   = DIR_NONE;
               state_d = ST_RELEASE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            dir_d = DIR_NONE;
`ifdef DIR_AUTOREPEAT_EN
            if (rpt_held && (rpt_cnt_q >= rpt_limit)) begin
               dir_d       = origin_q;
               state_d     = ST_HOLD;
               hold_d      = '0;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b0;
            end else
`endif
            if (level_w == 4'b0000) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
         end
      endcase
   end

   // FSM state, held direction and hold timer; reset clears the request at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_NONE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
      end
   end

`ifdef DIR_AUTOREPEAT_EN
   // Auto-repeat bookkeeping: originating direction and repeat timer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         origin_q    <= DIR_NONE;
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
      end else begin
         origin_q    <= origin_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
      end
   end
`endif

   assign direction = dir_q;
   assign dir_valid = (dir_q != DIR_NONE);

endmodule

// File: tb/tb_direction_input.sv
module tb_direction_input;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] key_n   = 4'hF;
   logic       dir_ack = 1'b0;
   logic [3:0] direction;
   logic       dir_valid;
   logic [3:0] key_level;

   direction_input #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (16),
      .CNT_W           (3)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .key_n     (key_n),
      .dir_ack   (dir_ack),
      .direction (direction),
      .dir_valid (dir_valid),
      .key_level (key_level)
   );

   initial forever #5 clock = ~clock;

   // Cycle number: count of rising edges seen so far.
   int cyc = 0;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   typedef struct {
      logic [3:0] dir;
      int         start;
      int         len;
   } req_t;

   req_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_req  = 0;

   // Request monitor: each completed request is popped against the scoreboard.
   initial begin
      logic       prev;
      logic [3:0] mdir;
      int         mstart;
      int         mlen;
      req_t       e;
      prev   = 1'b0;
      mdir   = 4'b0000;
      mstart = 0;
      forever begin
         @(negedge clock);
         if (dir_valid && !prev) begin
            mdir   = direction;
            mstart = cyc;
            n_req++;
         end
         if (!dir_valid && prev) begin
            mlen = cyc - mstart;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_request: got dir=%b start=%0d len=%0d, want none", mdir, mstart, mlen);
            end else begin
               e = exp_q.pop_front();
               if (mdir !== e.dir || mstart != e.start || mlen != e.len) begin
                  n_fail++;
                  $display("FAIL request: got dir=%b start=%0d len=%0d, want dir=%b start=%0d len=%0d",
                           mdir, mstart, mlen, e.dir, e.start, e.len);
               end
            end
         end
         prev = dir_valid;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      wait_cyc(3);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL rst_direction: got %b want 0000", direction); end
      n_cmp++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dir_valid: got %b want 0", dir_valid); end
      n_cmp++; if (key_level !== 4'b0000) begin n_fail++; $display("FAIL rst_key_level: got %b want 0000", key_level); end
      reset_n = 1'b1;
      wait_cyc(10);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL post_rst_direction: got %b want 0000", direction); end
   endtask

   task automatic test_clean_press();
      int t0, r0;
      t0 = cyc; r0 = n_req;
      key_n[2] = 1'b0;
      exp_q.push_back('{4'b0100, t0 + 7, 4});
      wait_cyc(5);
      n_cmp++; if (key_level[2] !== 1'b0) begin n_fail++; $display("FAIL clean_lvl_early: got %b want 0", key_level[2]); end
      wait_cyc(1);
      n_cmp++; if (key_level !== 4'b0100) begin n_fail++; $display("FAIL clean_lvl_rise: got %b want 0100", key_level); end
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL clean_dir_early: got %b want 0000", direction); end
      wait_cyc(1);
      n_cmp++; if (direction !== 4'b0100) begin n_fail++; $display("FAIL clean_dir: got %b want 0100", direction); end
      n_cmp++; if (dir_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b want 1", dir_valid); end
      wait_cyc(3);
      dir_ack = 1'b1;
      wait_cyc(1);
      dir_ack = 1'b0;
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL clean_ack_clear: got %b want 0000", direction); end
      wait_cyc(9);
      key_n[2] = 1'b1;
      wait_cyc(12);
      dir_ack = 1'b1;
      wait_cyc(1);
      dir_ack = 1'b0;
      wait_cyc(2);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL idle_ack_ignored: got %b want 0000", direction); end
      n_cmp++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL clean_req_count: got %0d want 1", n_req - r0); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clean_pending: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_bounce();
      int r0, ts;
      r0 = n_req;
      for (int i = 0; i < 4; i++) begin
         key_n[0] = i[0];
         wait_cyc(2);
         n_cmp++; if (key_level[0] !== 1'b0) begin n_fail++; $display("FAIL bounce_lvl_%0d: got %b want 0", i, key_level[0]); end
      end
      ts = cyc;
      key_n[0] = 1'b0;
      exp_q.push_back('{4'b0001, ts + 7, 16});
      wait_cyc(5);
      n_cmp++; if (key_level[0] !== 1'b0) begin n_fail++; $display("FAIL bounce_lvl_early: got %b want 0", key_level[0]); end
      wait_cyc(1);
      n_cmp++; if (key_level[0] !== 1'b1) begin n_fail++; $display("FAIL bounce_lvl_rise: got %b want 1", key_level[0]); end
      wait_cyc(24);
      key_n[0] = 1'b1;
      wait_cyc(12);
      n_cmp++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL bounce_req_count: got %0d want 1", n_req - r0); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bounce_pending: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_simultaneous();
      int t0, r0;
      t0 = cyc; r0 = n_req;
      key_n = 4'b0101;
      exp_q.push_back('{4'b0010, t0 + 7, 16});
      wait_cyc(7);
      n_cmp++; if (direction !== 4'b0010) begin n_fail++; $display("FAIL simul_dir: got %b want 0010", direction); end
      wait_cyc(23);
      key_n = 4'b0111;
      wait_cyc(12);
      key_n = 4'b0011;
      wait_cyc(14);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL simul_discard: got %b want 0000", direction); end
      key_n = 4'b1111;
      wait_cyc(12);
      n_cmp++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL simul_req_count: got %0d want 1", n_req - r0); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_pending: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      int t0, r0;
      t0 = cyc; r0 = n_req;
      key_n[3] = 1'b0;
      exp_q.push_back('{4'b1000, t0 + 7, 16});
      wait_cyc(22);
      n_cmp++; if (direction !== 4'b1000) begin n_fail++; $display("FAIL timeout_last: got %b want 1000", direction); end
      wait_cyc(1);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL timeout_drop: got %b want 0000", direction); end
      wait_cyc(27);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL timeout_release_wait: got %b want 0000", direction); end
      key_n[3] = 1'b1;
      wait_cyc(12);
      n_cmp++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL timeout_req_count: got %0d want 1", n_req - r0); end
   endtask

   task automatic test_ack_with_press();
      int t0, r0;
      t0 = cyc; r0 = n_req;
      key_n[2] = 1'b0;
      exp_q.push_back('{4'b0100, t0 + 7, 3});
      wait_cyc(3);
      key_n[0] = 1'b0;
      wait_cyc(6);
      dir_ack = 1'b1;
      wait_cyc(1);
      dir_ack = 1'b0;
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL ackpress_clear: got %b want 0000", direction); end
      wait_cyc(10);
      key_n[2] = 1'b1;
      wait_cyc(12);
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL ackpress_discard: got %b want 0000", direction); end
      key_n[0] = 1'b1;
      wait_cyc(12);
      n_cmp++; if (n_req - r0 != 1) begin n_fail++; $display("FAIL ackpress_req_count: got %0d want 1", n_req - r0); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ackpress_pending: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_hold();
      int t0, tr;
      t0 = cyc;
      key_n[3] = 1'b0;
      exp_q.push_back('{4'b1000, t0 + 7, 3});
      wait_cyc(9);
      n_cmp++; if (direction !== 4'b1000) begin n_fail++; $display("FAIL rsthold_before: got %b want 1000", direction); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (direction !== 4'b0000) begin n_fail++; $display("FAIL rsthold_async_dir: got %b want 0000", direction); end
      n_cmp++; if (dir_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_async_valid: got %b want 0", dir_valid); end
      n_cmp++; if (key_level !== 4'b0000) begin n_fail++; $display("FAIL rsthold_key_level: got %b want 0000", key_level); end
      wait_cyc(2);
      tr = cyc;
      reset_n = 1'b1;
      exp_q.push_back('{4'b1000, tr + 7, 16});
      wait_cyc(5);
      n_cmp++; if (key_level[3] !== 1'b0) begin n_fail++; $display("FAIL rsthold_lvl_early: got %b want 0", key_level[3]); end
      wait_cyc(1);
      n_cmp++; if (key_level[3] !== 1'b1) begin n_fail++; $display("FAIL rsthold_lvl_rise: got %b want 1", key_level[3]); end
      wait_cyc(24);
      key_n[3] = 1'b1;
      wait_cyc(12);
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rsthold_pending: got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_timeout();
      test_ack_with_press();
      test_reset_mid_hold();
      wait_cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
